// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared constants for the JESD204 TPL DAC sample-source stage.
// Holds the source-select codes and the PN seed/tap constants.
package ad_ip_jesd204_tpl_dac_pkg;

  localparam logic [3:0] SEL_DDS  = 4'd0;
  localparam logic [3:0] SEL_PAT  = 4'd1;
  localparam logic [3:0] SEL_DMA  = 4'd2;
  localparam logic [3:0] SEL_ZERO = 4'd3;
  localparam logic [3:0] SEL_PN7  = 4'd4;
  localparam logic [3:0] SEL_PN15 = 4'd5;
  localparam logic [3:0] SEL_RAMP = 4'd11;

  // Both LFSRs start from all ones.
  localparam logic [6:0]  PN7_SEED  = 7'h7f;
  localparam logic [14:0] PN15_SEED = 15'h7fff;

  // Fibonacci tap masks: x^7+x^6+1 -> bits 6,5; x^15+x^14+1 -> bits 14,13.
  localparam logic [6:0]  PN7_TAPS  = 7'h60;
  localparam logic [14:0] PN15_TAPS = 15'h6000;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_source_pn.sv
// Parallel Fibonacci LFSR for the PN7/PN15 test sources.
// Advances STEPS bits per enabled cycle; the bits of the current beat are
// presented combinationally on data_out, earliest bit at the MSB of each
// 16-bit sample, sample 0 in the low 16 bits.
// Ports: clk, rstn (async low), restart (reload seed this cycle),
//        enable (advance), data_out [STEPS-1:0].
module ad_ip_jesd204_tpl_dac_pn
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int POLY_WIDTH = 7,
  parameter int STEPS      = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             restart,
  input  logic             enable,
  output logic [STEPS-1:0] data_out
);

  localparam logic [15:0] TAPS_W = (POLY_WIDTH == 15) ? 16'(PN15_TAPS) : 16'(PN7_TAPS);
  localparam logic [15:0] SEED_W = (POLY_WIDTH == 15) ? 16'(PN15_SEED) : 16'(PN7_SEED);
  localparam logic [POLY_WIDTH-1:0] TAPS = TAPS_W[POLY_WIDTH-1:0];
  localparam logic [POLY_WIDTH-1:0] SEED = SEED_W[POLY_WIDTH-1:0];

  logic [POLY_WIDTH-1:0] state;
  logic [POLY_WIDTH-1:0] eff;
  logic [POLY_WIDTH-1:0] nxt;

  // A restart makes the seed the state for this very beat.
  always_comb begin
    eff      = restart ? SEED : state;
    nxt      = eff;
    data_out = '0;
    for (int i = 0; i < STEPS; i++) begin
      data_out[(i / 16) * 16 + 15 - (i % 16)] = nxt[POLY_WIDTH-1];
      nxt = {nxt[POLY_WIDTH-2:0], ^(nxt & TAPS)};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= SEED;
    else       state <= enable ? nxt : eff;
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_source.sv
// Per-channel DAC sample source: selects DDS, DMA, pattern, ramp, PN or
// zero into one registered beat of DATA_PATH_WIDTH 16-bit samples, and
// flags DMA underflow on dac_dunf aligned with the zero beat.
// Ports: link_clk/link_rstn (async low), dac_sync, dac_data_sel,
//        dac_pat_data_0/1, dds_data, dma_data, dma_valid -> dma_ready,
//        dac_data, dac_dunf.
// Build option: AD_IP_JESD204_TPL_DAC_PN_EN enables the PN7/PN15 sources;
// without it codes 4 and 5 produce zero.
module ad_ip_jesd204_tpl_dac_source
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4
) (
  input  logic                          link_clk,
  input  logic                          link_rstn,
  input  logic                          dac_sync,
  input  logic [3:0]                    dac_data_sel,
  input  logic [15:0]                   dac_pat_data_0,
  input  logic [15:0]                   dac_pat_data_1,
  input  logic [16*DATA_PATH_WIDTH-1:0] dds_data,
  input  logic [16*DATA_PATH_WIDTH-1:0] dma_data,
  input  logic                          dma_valid,
  output logic                          dma_ready,
  output logic [16*DATA_PATH_WIDTH-1:0] dac_data,
  output logic                          dac_dunf
);

  localparam int DW = 16 * DATA_PATH_WIDTH;

  logic [3:0]    sel_d;
  logic          restart;
  logic [15:0]   base;
  logic [15:0]   base_eff;
  logic          ramp_en;
  logic          pat_phase;
  logic          phase_eff;
  logic          pat_en;
  logic [DW-1:0] ramp_data;
  logic [DW-1:0] pat_data;
  logic [DW-1:0] pn7_data;
  logic [DW-1:0] pn15_data;
  logic [DW-1:0] nxt_data;
  logic          nxt_dunf;

  assign dma_ready = (dac_data_sel == SEL_DMA) && !dac_sync && link_rstn;
  assign restart   = dac_sync || (dac_data_sel != sel_d);

  // Restarted generators emit their seed in the same cycle.
  assign ramp_en   = (dac_data_sel == SEL_RAMP) && !dac_sync;
  assign base_eff  = restart ? 16'd0 : base;
  assign pat_en    = (dac_data_sel == SEL_PAT) && !dac_sync;
  assign phase_eff = restart ? 1'b0 : pat_phase;

  for (genvar k = 0; k < DATA_PATH_WIDTH; k++) begin : g_smp
    localparam bit ODD = (k % 2) == 1;
    assign ramp_data[16*k +: 16] = base_eff + 16'(k);
    // phase_eff only toggles in the single-sample build, alternating beats.
    assign pat_data[16*k +: 16]  = (ODD ^ phase_eff) ? dac_pat_data_1 : dac_pat_data_0;
  end

`ifdef AD_IP_JESD204_TPL_DAC_PN_EN
  ad_ip_jesd204_tpl_dac_pn #(.POLY_WIDTH(7), .STEPS(DW)) i_pn7 (
    .clk      (link_clk),
    .rstn     (link_rstn),
    .restart  (restart),
    .enable   ((dac_data_sel == SEL_PN7) && !dac_sync),
    .data_out (pn7_data)
  );

  ad_ip_jesd204_tpl_dac_pn #(.POLY_WIDTH(15), .STEPS(DW)) i_pn15 (
    .clk      (link_clk),
    .rstn     (link_rstn),
    .restart  (restart),
    .enable   ((dac_data_sel == SEL_PN15) && !dac_sync),
    .data_out (pn15_data)
  );
`else
  assign pn7_data  = '0;
  assign pn15_data = '0;
`endif

  always_comb begin
    nxt_data = '0;
    nxt_dunf = 1'b0;
    if (!dac_sync) begin
      case (dac_data_sel)
        SEL_DDS:  nxt_data = dds_data;
        SEL_PAT:  nxt_data = pat_data;
        SEL_DMA: begin
          if (dma_valid) nxt_data = dma_data;
          else           nxt_dunf = 1'b1;
        end
        SEL_PN7:  nxt_data = pn7_data;
        SEL_PN15: nxt_data = pn15_data;
        SEL_RAMP: nxt_data = ramp_data;
        default:  nxt_data = '0;
      endcase
    end
  end

  always_ff @(posedge link_clk or negedge link_rstn) begin
    if (!link_rstn) begin
      sel_d     <= SEL_ZERO;
      base      <= 16'd0;
      pat_phase <= 1'b0;
      dac_data  <= '0;
      dac_dunf  <= 1'b0;
    end else begin
      sel_d     <= dac_data_sel;
      base      <= ramp_en ? base_eff + 16'(DATA_PATH_WIDTH) : base_eff;
      pat_phase <= (pat_en && (DATA_PATH_WIDTH == 1)) ? ~phase_eff : phase_eff;
      dac_data  <= nxt_data;
      dac_dunf  <= nxt_dunf;
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_source.sv
// Scoreboard bench for the DAC sample source. A driver applies one beat of
// inputs per cycle and pushes the reference model's expected output; a
// monitor pops and compares after each rising edge.
module tb_ad_ip_jesd204_tpl_dac_source;

  localparam int DPW = 4;
  localparam int DW  = 16 * DPW;

  logic          link_clk = 1'b0;
  logic          link_rstn = 1'b0;
  logic          dac_sync = 1'b0;
  logic [3:0]    dac_data_sel = 4'd2;
  logic [15:0]   dac_pat_data_0 = '0;
  logic [15:0]   dac_pat_data_1 = '0;
  logic [DW-1:0] dds_data = '0;
  logic [DW-1:0] dma_data = '0;
  logic          dma_valid = 1'b0;
  logic          dma_ready;
  logic [DW-1:0] dac_data;
  logic          dac_dunf;

  ad_ip_jesd204_tpl_dac_source #(.DATA_PATH_WIDTH(DPW)) dut (
    .link_clk       (link_clk),
    .link_rstn      (link_rstn),
    .dac_sync       (dac_sync),
    .dac_data_sel   (dac_data_sel),
    .dac_pat_data_0 (dac_pat_data_0),
    .dac_pat_data_1 (dac_pat_data_1),
    .dds_data       (dds_data),
    .dma_data       (dma_data),
    .dma_valid      (dma_valid),
    .dma_ready      (dma_ready),
    .dac_data       (dac_data),
    .dac_dunf       (dac_dunf)
  );

  always #5 link_clk = ~link_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          dunf;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  // reference model state
  int   m_prev = 3;
  int   m_base = 0;
  int   m_pn7  = 127;
  int   m_pn15 = 32767;
  logic [15:0] np0 = '0, np1 = '0;
`ifdef AD_IP_JESD204_TPL_DAC_PN_EN
  bit   pn_en = 1'b1;
`else
  bit   pn_en = 1'b0;
`endif

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Bit-serial golden LFSR: emit MSB, shift in feedback of the top two bits.
  function automatic logic [DW-1:0] pn_beat(inout int s, input int n);
    logic [DW-1:0] r;
    int v;
    int b;
    r = '0;
    for (int k = 0; k < DPW; k++) begin
      v = 0;
      for (int j = 0; j < 16; j++) begin
        b = (s >> (n - 1)) & 1;
        v = (v << 1) | b;
        s = ((s << 1) | (b ^ ((s >> (n - 2)) & 1))) & ((1 << n) - 1);
      end
      r[16*k +: 16] = 16'(v);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_prev = 3;
    m_base = 0;
    m_pn7  = 127;
    m_pn15 = 32767;
  endtask

  task automatic drive_now(input logic [3:0] sel, input logic sync, input logic valid);
    exp_t e;
    dac_data_sel   = sel;
    dac_sync       = sync;
    dma_valid      = valid;
    dac_pat_data_0 = np0;
    dac_pat_data_1 = np1;
    dds_data       = {$urandom, $urandom};
    dma_data       = {$urandom, $urandom};
    if (sync || int'(sel) != m_prev) begin
      m_base = 0;
      m_pn7  = 127;
      m_pn15 = 32767;
    end
    m_prev = int'(sel);
    e.data = '0;
    e.dunf = 1'b0;
    if (!sync) begin
      case (int'(sel))
        0: e.data = dds_data;
        1: for (int k = 0; k < DPW; k++) e.data[16*k +: 16] = (k % 2 == 0) ? np0 : np1;
        2: if (valid) e.data = dma_data; else e.dunf = 1'b1;
        4: if (pn_en) e.data = pn_beat(m_pn7, 7);
        5: if (pn_en) e.data = pn_beat(m_pn15, 15);
        11: begin
          for (int k = 0; k < DPW; k++) e.data[16*k +: 16] = 16'((m_base + k) % 65536);
          m_base = (m_base + DPW) % 65536;
        end
        default: e.data = '0;
      endcase
    end
    expq.push_back(e);
    #1;
    chk("dma_ready", DW'(dma_ready), DW'(sel == 4'd2 && !sync && link_rstn));
  endtask

  task automatic drive(input logic [3:0] sel, input logic sync, input logic valid);
    @(negedge link_clk);
    drive_now(sel, sync, valid);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 10) begin
      @(posedge link_clk);
      n++;
    end
    #2;
    tests++;
    if (expq.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d beats never appeared, expected 0", expq.size());
      expq.delete();
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge link_clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        tests++;
        if (dac_data !== e.data || dac_dunf !== e.dunf) begin
          fails++;
          $display("FAIL beat: got data %h dunf %b expected data %h dunf %b",
                   dac_data, dac_dunf, e.data, e.dunf);
        end
      end
    end
  end

  initial begin
    logic [3:0] codes [8];
    codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd11, 4'd7};

    // reset values
    #2;
    chk("rst_data", dac_data, '0);
    chk("rst_dunf", DW'(dac_dunf), '0);
    chk("rst_ready", DW'(dma_ready), '0);
    @(negedge link_clk);
    @(negedge link_clk);
    link_rstn = 1'b1;
    drive_now(4'd11, 1'b0, 1'b0);

    // ramp through the 16-bit wrap
    repeat (16400) drive(4'd11, 1'b0, 1'b0);

    // pattern, then a mid-stream pattern change
    np0 = 16'h1234; np1 = 16'hABCD;
    repeat (5) drive(4'd1, 1'b0, 1'b0);
    np1 = 16'h5555;
    repeat (3) drive(4'd1, 1'b0, 1'b0);

    // DMA valid 1,1,0,1 then random
    drive(4'd2, 1'b0, 1'b1);
    drive(4'd2, 1'b0, 1'b1);
    drive(4'd2, 1'b0, 1'b0);
    drive(4'd2, 1'b0, 1'b1);
    repeat (40) drive(4'd2, 1'b0, 1'($urandom_range(1)));

    // PN7 with a 4->3->4 restart, then PN15
    repeat (64) drive(4'd4, 1'b0, 1'b0);
    drive(4'd3, 1'b0, 1'b0);
    repeat (8) drive(4'd4, 1'b0, 1'b0);
    repeat (64) drive(4'd5, 1'b0, 1'b0);

    // sync during ramp and DMA
    repeat (5) drive(4'd11, 1'b0, 1'b0);
    repeat (3) drive(4'd11, 1'b1, 1'b0);
    repeat (5) drive(4'd11, 1'b0, 1'b0);
    repeat (3) drive(4'd2, 1'b0, 1'b1);
    repeat (3) drive(4'd2, 1'b1, 1'b0);
    drive(4'd2, 1'b0, 1'b0);

    // sync and sel change together
    repeat (3) drive(4'd1, 1'b0, 1'b0);
    drive(4'd11, 1'b1, 1'b0);
    repeat (3) drive(4'd11, 1'b0, 1'b0);

    // reset mid-ramp
    repeat (6) drive(4'd11, 1'b0, 1'b0);
    drain();
    @(negedge link_clk);
    #2;
    link_rstn = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_data", dac_data, '0);
    chk("mid_rst_dunf", DW'(dac_dunf), '0);
    dac_data_sel = 4'd2;
    #1;
    chk("mid_rst_ready", DW'(dma_ready), '0);
    dac_data_sel = 4'd11;
    @(negedge link_clk);
    @(negedge link_clk);
    link_rstn = 1'b1;
    drive_now(4'd11, 1'b0, 1'b0);
    repeat (4) drive(4'd11, 1'b0, 1'b0);

    // random mix
    for (int i = 0; i < 400; i++) begin
      np0 = 16'($urandom); np1 = 16'($urandom);
      drive(codes[$urandom_range(7)], 1'($urandom_range(15) == 0), 1'($urandom_range(1)));
    end

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
